// File: rtl/csa_reduce_pipe.sv
// Pipelined carry-save tree: NUM_IN operands reduced to S1/S2, one register per level.
// Define CSA_FINAL_ADD_EN to add sum_out = S1 + S2 after the last stage.
module csa_reduce_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_ops,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        S1,
  output logic [WIDTH-1:0]        S2,
  output logic                    out_valid,
`ifdef CSA_FINAL_ADD_EN
  output logic [WIDTH-1:0]        sum_out,
`endif
  input  logic                    out_ready
);

  function automatic int next_cnt(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int cnt_at(input int k);
    int c;
    c = NUM_IN;
    for (int i = 0; i < k; i++) c = next_cnt(c);
    return c;
  endfunction

  function automatic int lvl_num();
    int c;
    int l;
    c = NUM_IN;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if (c > 2) begin
        c = next_cnt(c);
        l++;
      end
    end
    return l;
  endfunction

  function automatic logic [WIDTH-1:0] maj(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  localparam int L = lvl_num();

  if (NUM_IN < 3 || NUM_IN > 8) begin : g_bad
    $error("csa_reduce_pipe: NUM_IN must be in 3..8");
  end

  genvar k;
  for (k = 0; k < L; k++) begin : g_lvl
    localparam int NI = cnt_at(k);
    localparam int NO = cnt_at(k + 1);
    localparam int NG = NI / 3;
    localparam int NR = NI % 3;

    logic [NI-1:0][WIDTH-1:0] w_src;
    logic [NO-1:0][WIDTH-1:0] w_nxt;
    logic [NO-1:0][WIDTH-1:0] r_data;
    logic                     r_vld;
    logic                     w_up_vld;
    logic                     w_dn_rdy;
    logic                     w_rdy;

    if (k == 0) begin : g_head
      assign w_src    = in_ops;
      assign w_up_vld = in_valid;
    end else begin : g_body
      assign w_src    = g_lvl[k-1].r_data;
      assign w_up_vld = g_lvl[k-1].r_vld;
    end

    if (k == L - 1) begin : g_tail
      assign w_dn_rdy = out_ready;
    end else begin : g_mid
      assign w_dn_rdy = g_lvl[k+1].w_rdy;
    end

    // a stage may take new data when empty or when its content moves on
    assign w_rdy = !r_vld || w_dn_rdy;

    always_comb begin
      w_nxt = '0;
      for (int g = 0; g < NG; g++) begin
        w_nxt[2*g] = w_src[3*g] ^ w_src[3*g+1] ^ w_src[3*g+2];
        w_nxt[2*g+1] =
          maj(w_src[3*g], w_src[3*g+1], w_src[3*g+2]) << 1;
      end
      for (int r = 0; r < NR; r++) begin
        w_nxt[2*NG+r] = w_src[3*NG+r];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_data <= '0;
      end else if (w_rdy) begin
        r_vld <= w_up_vld;
        if (w_up_vld) r_data <= w_nxt;
      end
    end
  end

  assign in_ready  = g_lvl[0].w_rdy;
  assign out_valid = g_lvl[L-1].r_vld;
  assign S1        = g_lvl[L-1].r_data[0];
  assign S2        = g_lvl[L-1].r_data[1];

`ifdef CSA_FINAL_ADD_EN
  assign sum_out = S1 + S2;
`endif

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Bench for csa_reduce_pipe: sum-level model with a queue, directed phases,
// plus a NUM_IN=3..8 sweep at WIDTH=8.
module tb_csa_reduce_pipe;
  localparam int W   = 32;
  localparam int N   = 5;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_ops;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   S1;
  logic [W-1:0]   S2;
  logic           out_valid;
  logic           out_ready;
`ifdef CSA_FINAL_ADD_EN
  logic [W-1:0]   sum_out;
`endif

  csa_reduce_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ops    (in_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S1        (S1),
    .S2        (S2),
    .out_valid (out_valid),
`ifdef CSA_FINAL_ADD_EN
    .sum_out   (sum_out),
`endif
    .out_ready (out_ready)
  );

  logic       sw_valid;
  logic [5:0] sw_ov;
  logic [5:0] sw_ir;
  logic [7:0] sw_sum [6];
`ifdef CSA_FINAL_ADD_EN
  logic [7:0] sw_so [6];
`endif

  for (genvar i = 0; i < 6; i++) begin : g_sw
    localparam int NI = i + 3;
    logic [7:0] s1;
    logic [7:0] s2;
    csa_reduce_pipe #(.WIDTH(8), .NUM_IN(NI)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ops    ({NI{8'h01}}),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[i]),
      .S1        (s1),
      .S2        (s2),
      .out_valid (sw_ov[i]),
`ifdef CSA_FINAL_ADD_EN
      .sum_out   (sw_so[i]),
`endif
      .out_ready (1'b1)
    );
    assign sw_sum[i] = s1 + s2;
  end

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int tick = 0;
  bit lat_chk = 1'b1;

  typedef struct {
    logic [W-1:0] sum;
    int           t;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  bit           p_stall = 1'b0;
  logic [W-1:0] p_s1;
  logic [W-1:0] p_s2;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] d);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + d[i*W +: W];
    return s;
  endfunction

  function automatic logic [W-1:0] pair(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    return a + b;
  endfunction

  // compare process: every transfer in/out observed mid-cycle
  always @(negedge clk) begin
    tick++;
    if (!rst_n) begin
      q.delete();
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_s1", S1, p_s1);
        chk("stall_s2", S2, p_s2);
      end
      if (out_valid && out_ready) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sum", pair(S1, S2), e.sum);
`ifdef CSA_FINAL_ADD_EN
          chk("sum_out", sum_out, e.sum);
`endif
          if (lat_chk) chk("latency", tick - e.t, LAT);
        end
      end
      p_stall = out_valid && !out_ready;
      p_s1 = S1;
      p_s2 = S2;
      if (in_valid && in_ready) q.push_back('{ref_sum(in_ops), tick});
    end
  end

  task automatic send(input logic [N*W-1:0] d);
    int t;
    t = 0;
    in_ops = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 20);
    chk("wait_out", out_valid, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] rnd_ops();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  logic [N*W-1:0] d;
  logic [N*W-1:0] bp_set [4];
  int             t0;
  int             acc;
  bit             fired;
  int             idx;
  int             lat [6];
  logic [7:0]     ssum [6];
  int             exp_lat [6] = '{1, 2, 3, 3, 4, 4};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_ops = '0;
    out_ready = 1'b1;
    sw_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_s1", S1, 0);
    chk("rst_s2", S2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // mid-stream asynchronous reset
    for (int i = 0; i < 4; i++) send(rnd_ops());
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_s1", S1, 0);
    chk("arst_s2", S2, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < N; i++) d[i*W +: W] = W'(i + 1);
    send(d);
    in_valid = 1'b0;
    wait_out();
    chk("lit12345_s1", S1, 32'd15);
    chk("lit12345_s2", S2, 32'd0);
    drain();

    // back-to-back stream
    t0 = tick;
    for (int i = 0; i < 100; i++) send(rnd_ops());
    in_valid = 1'b0;
    chk("stream_rate", tick - t0, 100);
    drain();

    // wrap-around
    send({N{32'hFFFF_FFFF}});
    in_valid = 1'b0;
    wait_out();
    chk("ovf_s1", S1, 32'hFFFF_FFFF);
    chk("ovf_s2", S2, 32'hFFFF_FFFC);
    chk("ovf_sum", pair(S1, S2), 32'hFFFF_FFFB);
    drain();

    // backpressure
    lat_chk = 1'b0;
    for (int i = 0; i < 4; i++) bp_set[i] = rnd_ops();
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_ops = bp_set[idx];
      @(negedge clk);
      fired = in_ready;
      if (fired) acc++;
      @(posedge clk);
      #1;
      if (fired && idx < 3) idx++;
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    lat_chk = 1'b1;

    // bubbles: 1,0,1
    send(rnd_ops());
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    send(rnd_ops());
    in_valid = 1'b0;
    wait_out();
    @(negedge clk);
    chk("bubble_gap", out_valid, 0);
    @(negedge clk);
    chk("bubble_v2", out_valid, 1);
    drain();

    // operand-count sweep at WIDTH=8
    chk("sw_ready", sw_ir, 6'h3F);
    for (int i = 0; i < 6; i++) begin
      lat[i] = 0;
      ssum[i] = '0;
    end
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (sw_ov[i] && lat[i] == 0) begin
          lat[i] = c;
          ssum[i] = sw_sum[i];
`ifdef CSA_FINAL_ADD_EN
          chk($sformatf("sw_sumout_n%0d", i + 3), sw_so[i], i + 3);
`endif
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sw_lat_n%0d", i + 3), lat[i], exp_lat[i]);
      chk($sformatf("sw_sum_n%0d", i + 3), ssum[i], i + 3);
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
